// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: sequencer in front of the src1/src2 operand memories.
// Steps a PC over an internal program ROM, decodes each word, drives the
// registered operand read addresses, waits out the memory read latency, then
// presents the op to the ALU with a valid/ready handshake. Stops on HALT (op 111).
//
// Parameters:
//   PC_W      PC width; ROM depth is 2**PC_W words
//   READ_LAT  operand-memory read latency in cycles (>= 1)
//   ROM_IMAGE program image, word i at bits [8*i +: 8]; default is a two-op
//             program followed by HALT words
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   start                 begin execution at PC 0 (honoured in IDLE/DONE only)
//   src1_addr, src2_addr  operand memory read addresses
//   alu_op, alu_valid     op to the ALU and its valid flag
//   alu_ready             ALU accepts the op when alu_valid && alu_ready
//   busy, done            running / halted status levels
//   pc                    address of the current instruction
//   instr_count           ops retired since last start, saturating at 255
module operand_fetch_ctrl #(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned READ_LAT = 1,
  parameter logic [8*(2**PC_W)-1:0] ROM_IMAGE = {{(2**PC_W-2){8'hE0}}, 8'h36, 8'h02}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [1:0]      src1_addr,
  output logic [1:0]      src2_addr,
  output logic [2:0]      alu_op,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic            busy,
  output logic            done,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      instr_count
);

  localparam int unsigned CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_EXEC   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [2:0] OP_HALT  = 3'b111;

  logic [2:0]       state, state_nxt;
  logic [7:1]       instr, instr_nxt;   // bit 0 of the word is don't-care, never stored
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [1:0]       src1_nxt, src2_nxt;
  logic [2:0]       op_nxt;
  logic [7:0]       count_nxt;
  logic [PC_W+2:0]  rom_base;

  // Next-state and next-datapath logic
  always_comb begin
    state_nxt = state;
    instr_nxt = instr;
    cnt_nxt   = cnt;
    pc_nxt    = pc;
    src1_nxt  = src1_addr;
    src2_nxt  = src2_addr;
    op_nxt    = alu_op;
    count_nxt = instr_count;
    rom_base  = {pc, 3'b001};  // skip the ignored bit 0 of the addressed word

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          count_nxt = '0;
        end
      end
      S_FETCH: begin
        instr_nxt = ROM_IMAGE[rom_base +: 7];
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (instr[7:5] == OP_HALT) begin
          state_nxt = S_DONE;
        end else begin
          src1_nxt  = instr[4:3];
          src2_nxt  = instr[2:1];
          op_nxt    = instr[7:5];
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (READ_LAT <= 1) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_W'(READ_LAT - 2);
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_EXEC;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_EXEC: begin
        // Addresses and op are held while stalled so the memories keep
        // re-reading the same operands.
        if (alu_ready) begin
          count_nxt = (instr_count == 8'hFF) ? instr_count : instr_count + 8'd1;
          pc_nxt    = pc + PC_W'(1);
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath and status registers; status flags are decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      cnt         <= '0;
      pc          <= '0;
      src1_addr   <= '0;
      src2_addr   <= '0;
      alu_op      <= '0;
      instr_count <= '0;
      alu_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      instr       <= instr_nxt;
      cnt         <= cnt_nxt;
      pc          <= pc_nxt;
      src1_addr   <= src1_nxt;
      src2_addr   <= src2_nxt;
      alu_op      <= op_nxt;
      instr_count <= count_nxt;
      alu_valid   <= (state_nxt == S_EXEC);
      busy        <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done        <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
module tb_operand_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Main instance: default ROM, READ_LAT = 1
  logic       start, alu_ready;
  logic [1:0] src1_addr, src2_addr;
  logic [2:0] alu_op;
  logic       alu_valid, busy, done;
  logic [3:0] pc;
  logic [7:0] instr_count;

  operand_fetch_ctrl #(.PC_W(4), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .alu_op(alu_op), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .busy(busy), .done(done), .pc(pc), .instr_count(instr_count)
  );

  // Latency-3 instance with an operand memory model
  logic       start_l, ready_l;
  logic [1:0] s1_l, s2_l;
  logic [2:0] op_l;
  logic       valid_l, busy_l, done_l;
  logic [3:0] pc_l;
  logic [7:0] cnt_l;

  operand_fetch_ctrl #(.PC_W(4), .READ_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst), .start(start_l),
    .src1_addr(s1_l), .src2_addr(s2_l),
    .alu_op(op_l), .alu_valid(valid_l), .alu_ready(ready_l),
    .busy(busy_l), .done(done_l), .pc(pc_l), .instr_count(cnt_l)
  );

  // Registered memory with 3-cycle read latency: data reflects the address of 3 edges ago
  logic [5:0] dly1 = '0, dly2 = '0;
  always @(posedge clk) begin
    dly1 <= {dly1[3:0], s1_l};
    dly2 <= {dly2[3:0], s2_l};
  end
  logic [7:0] src1_data, src2_data;
  assign src1_data = 8'h10 + {6'b0, dly1[5:4]};
  assign src2_data = 8'h20 + {6'b0, dly2[5:4]};

  // Wrap instance: 16 non-HALT words
  logic       start_w, ready_w;
  logic [1:0] s1_w, s2_w;
  logic [2:0] op_w;
  logic       valid_w, busy_w, done_w;
  logic [3:0] pc_w;
  logic [7:0] cnt_w;

  operand_fetch_ctrl #(.PC_W(4), .READ_LAT(1), .ROM_IMAGE({16{8'h36}})) dut_wrap (
    .clk(clk), .rst(rst), .start(start_w),
    .src1_addr(s1_w), .src2_addr(s2_w),
    .alu_op(op_w), .alu_valid(valid_w), .alu_ready(ready_w),
    .busy(busy_w), .done(done_w), .pc(pc_w), .instr_count(cnt_w)
  );

  typedef struct {
    logic       start;
    logic       ready;
    logic       valid;
    logic       busy;
    logic       done;
    logic [2:0] op;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [3:0] pc;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] obs();
    return {alu_valid, busy, done, alu_op, src1_addr, src2_addr, pc, instr_count};
  endfunction

  initial begin
    logic [21:0] exp_v;
    int n;
    int retired;
    int prev_pc;
    bit wrap_seen;

    rst = 1'b0; start = 1'b0; alu_ready = 1'b1;
    start_l = 1'b0; ready_l = 1'b1;
    start_w = 1'b0; ready_w = 1'b1;

    //  start ready  v  b  d  op s1 s2 pc cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 4'd0, 8'd0}; // FETCH
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 4'd0, 8'd0}; // DECODE
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd1, 4'd0, 8'd0}; // ISSUE
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 2'd1, 4'd0, 8'd0}; // EXEC op0
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd1, 4'd1, 8'd1}; // FETCH
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd1, 4'd1, 8'd1}; // DECODE
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 2'd2, 2'd3, 4'd1, 8'd1}; // ISSUE
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 2'd2, 2'd3, 4'd1, 8'd1}; // EXEC op1
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 2'd2, 2'd3, 4'd2, 8'd2}; // FETCH HALT
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 2'd2, 2'd3, 4'd2, 8'd2}; // DECODE
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 2'd2, 2'd3, 4'd2, 8'd2}; // DONE
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 2'd2, 2'd3, 4'd2, 8'd2}; // DONE held

    // Reset state
    #2 rst = 1'b1;
    #1 chk("reset_state", 32'(obs()), 32'd0);
    #5 rst = 1'b0;
    step();

    // Default program, ready tied high
    foreach (vecs[i]) begin
      start = vecs[i].start;
      alu_ready = vecs[i].ready;
      step();
      exp_v = {vecs[i].valid, vecs[i].busy, vecs[i].done, vecs[i].op,
               vecs[i].s1, vecs[i].s2, vecs[i].pc, vecs[i].cnt};
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(exp_v));
    end

    // Start in DONE restarts from PC 0 with a cleared count
    start = 1'b1; step();
    chk("restart_from_done", 32'({busy, done, pc, instr_count}), 32'({1'b1, 1'b0, 4'd0, 8'd0}));
    start = 1'b0; step(); step(); step();
    chk("restart_exec", 32'({alu_valid, alu_op}), 32'({1'b1, 3'd0}));
    // Start while busy is ignored
    start = 1'b1; step();
    chk("start_busy_exec", 32'({busy, pc, instr_count}), 32'({1'b1, 4'd1, 8'd1}));
    step();
    chk("start_busy_fetch", 32'({busy, pc, instr_count}), 32'({1'b1, 4'd1, 8'd1}));
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("second_done", 32'({done, pc, instr_count}), 32'({1'b1, 4'd2, 8'd2}));

    // Stall in the first EXEC
    start = 1'b1; step();
    start = 1'b0; alu_ready = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d", i), 32'(obs()),
          32'({1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 2'd1, 4'd0, 8'd0}));
      step();
    end
    alu_ready = 1'b1;
    chk("stall_last", 32'({alu_valid, pc, instr_count}), 32'({1'b1, 4'd0, 8'd0}));
    step();
    chk("after_stall", 32'({alu_valid, pc, instr_count}), 32'({1'b0, 4'd1, 8'd1}));

    // Async reset in the middle of the second EXEC
    step(); step(); step();
    chk("pre_reset_exec", 32'({alu_valid, pc, instr_count}), 32'({1'b1, 4'd1, 8'd1}));
    #2 rst = 1'b1;
    #1 chk("async_reset", 32'({alu_valid, busy, pc, instr_count}), 32'd0);
    #1 rst = 1'b0;
    step();
    chk("idle_after_reset", 32'(obs()), 32'd0);

    // READ_LAT = 3: six edges from start to alu_valid, memory data matches ROM fields
    start_l = 1'b1;
    n = 0;
    do begin
      step();
      start_l = 1'b0;
      n++;
    end while (!valid_l && n < 20);
    chk("lat3_first_valid_edges", 32'(n), 32'd6);
    chk("lat3_op0_data", 32'({op_l, src1_data, src2_data}), 32'({3'd0, 8'h10, 8'h21}));
    n = 0;
    do begin step(); n++; end while (!valid_l && n < 20);
    chk("lat3_op_spacing", 32'(n), 32'd6);
    chk("lat3_op1_data", 32'({op_l, src1_data, src2_data, pc_l}),
        32'({3'd1, 8'h12, 8'h23, 4'd1}));
    n = 0;
    do begin step(); n++; end while (!done_l && n < 20);
    chk("lat3_done", 32'({done_l, pc_l, cnt_l}), 32'({1'b1, 4'd2, 8'd2}));

    // No HALT: PC wraps and the retire count saturates
    start_w = 1'b1; step(); start_w = 1'b0;
    retired = 0; n = 0; wrap_seen = 1'b0;
    while (retired < 300 && n < 5000) begin
      prev_pc = int'(pc_w);
      if (valid_w) retired++;
      step();
      n++;
      if (prev_pc == 15 && pc_w != 4'd15 && !wrap_seen) begin
        wrap_seen = 1'b1;
        chk("pc_wrap", 32'(pc_w), 32'd0);
      end
      if (retired == 100 && valid_w == 1'b0 && prev_pc == 3)
        chk("count_100", 32'(cnt_w), 32'd100);
    end
    chk("wrap_budget", 32'({wrap_seen, retired == 300}), 32'b11);
    chk("count_saturated", 32'({cnt_w, pc_w}), 32'({8'd255, 4'd12}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
